// File: rtl/traffic.sv
// rtl/traffic.sv - two-road traffic-light FSM with per-state minimum dwell
// Define TRAFFIC_DEBUG_EN to expose state_o / dwell_o debug ports.
module traffic #(
  parameter int GREEN_MIN  = 1,
  parameter int YELLOW_LEN = 1,
  localparam int MAX_DWELL = (GREEN_MIN > YELLOW_LEN) ? GREEN_MIN : YELLOW_LEN,
  localparam int DW        = $clog2(MAX_DWELL) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x1,
  output logic [1:0] horizontal_light,
  output logic [1:0] vertical_light
`ifdef TRAFFIC_DEBUG_EN
  ,
  output logic [1:0]    state_o,
  output logic [DW-1:0] dwell_o
`endif
);

  typedef enum logic [1:0] {
    H_RED_V_GREEN       = 2'b00,
    H_YELLOW_V_YELLOW   = 2'b01,
    H_GREEN_V_RED       = 2'b10,
    H_YELLOW_V_YELLOW_2 = 2'b11
  } state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b10;
  localparam logic [1:0] GREEN  = 2'b11;

  localparam logic [DW-1:0] GREEN_THR  = DW'(GREEN_MIN - 1);
  localparam logic [DW-1:0] YELLOW_THR = DW'(YELLOW_LEN - 1);

  state_t        current_state;
  state_t        next_state;
  logic [DW-1:0] dwell_cnt;
  logic          dwell_ok;
  logic          advance;

  // State register and dwell counter; counter restarts on every state change
  // and otherwise saturates so a long hold cannot wrap it below threshold.
  always_ff @(posedge clk) begin
    if (reset) begin
      current_state <= H_RED_V_GREEN;
      dwell_cnt     <= '0;
    end else begin
      current_state <= next_state;
      if (advance) begin
        dwell_cnt <= '0;
      end else if (dwell_cnt != {DW{1'b1}}) begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    dwell_ok   = 1'b0;
    next_state = H_RED_V_GREEN;
    case (current_state)
      H_RED_V_GREEN: begin
        dwell_ok   = (dwell_cnt >= GREEN_THR);
        next_state = H_YELLOW_V_YELLOW;
      end
      H_YELLOW_V_YELLOW: begin
        dwell_ok   = (dwell_cnt >= YELLOW_THR);
        next_state = H_GREEN_V_RED;
      end
      H_GREEN_V_RED: begin
        dwell_ok   = (dwell_cnt >= GREEN_THR);
        next_state = H_YELLOW_V_YELLOW_2;
      end
      H_YELLOW_V_YELLOW_2: begin
        dwell_ok   = (dwell_cnt >= YELLOW_THR);
        next_state = H_RED_V_GREEN;
      end
      default: begin
        dwell_ok   = 1'b1;
        next_state = H_RED_V_GREEN;
      end
    endcase
    advance = !x1 && dwell_ok;
    if (!advance) begin
      next_state = current_state;
    end
  end

  always_comb begin
    horizontal_light = RED;
    vertical_light   = RED;
    case (current_state)
      H_RED_V_GREEN: begin
        horizontal_light = RED;
        vertical_light   = GREEN;
      end
      H_YELLOW_V_YELLOW, H_YELLOW_V_YELLOW_2: begin
        horizontal_light = YELLOW;
        vertical_light   = YELLOW;
      end
      H_GREEN_V_RED: begin
        horizontal_light = GREEN;
        vertical_light   = RED;
      end
      default: begin
        horizontal_light = RED;
        vertical_light   = RED;
      end
    endcase
  end

`ifdef TRAFFIC_DEBUG_EN
  assign state_o = current_state;
  assign dwell_o = dwell_cnt;
`endif

endmodule

// File: tb/tb_traffic.sv
// tb/tb_traffic.sv - directed-vector bench for traffic (default and slow-dwell instances)
module tb_traffic;

  logic       clk = 1'b0;
  logic       reset_a, x1_a, reset_b, x1_b;
  logic [1:0] h_a, v_a, h_b, v_b;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  traffic u_dut (
    .clk(clk), .reset(reset_a), .x1(x1_a),
    .horizontal_light(h_a), .vertical_light(v_a)
  );

  traffic #(.GREEN_MIN(3), .YELLOW_LEN(2)) u_slow (
    .clk(clk), .reset(reset_b), .x1(x1_b),
    .horizontal_light(h_b), .vertical_light(v_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] lamp_h(input logic [1:0] s);
    case (s)
      2'b00:   lamp_h = 2'b00;
      2'b10:   lamp_h = 2'b11;
      default: lamp_h = 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] lamp_v(input logic [1:0] s);
    case (s)
      2'b00:   lamp_v = 2'b11;
      2'b10:   lamp_v = 2'b00;
      default: lamp_v = 2'b10;
    endcase
  endfunction

  task automatic edge_once();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic [1:0] s);
    check({tag, ".state"}, 32'(u_dut.current_state), 32'(s));
    check({tag, ".h"}, 32'(h_a), 32'(lamp_h(s)));
    check({tag, ".v"}, 32'(v_a), 32'(lamp_v(s)));
    check({tag, ".no01"}, 32'((h_a == 2'b01) || (v_a == 2'b01)), 32'd0);
  endtask

  task automatic expect_b(input string tag, input logic [1:0] s);
    check({tag, ".state"}, 32'(u_slow.current_state), 32'(s));
    check({tag, ".h"}, 32'(h_b), 32'(lamp_h(s)));
    check({tag, ".v"}, 32'(v_b), 32'(lamp_v(s)));
  endtask

  logic [1:0] seq4 [4];
  logic [1:0] slow_pat [10];

  initial begin
    seq4     = '{2'b01, 2'b10, 2'b11, 2'b00};
    slow_pat = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};

    reset_a = 1'b1; x1_a = 1'b1;
    reset_b = 1'b1; x1_b = 1'b1;

    // reset held two edges with x1 high
    edge_once();
    expect_a("rst1", 2'b00);
    check("rst1.h_raw", 32'(h_a), 32'h0);
    check("rst1.v_raw", 32'(v_a), 32'h3);
    check("rst1.dwell", 32'(u_dut.dwell_cnt), 32'd0);
    edge_once();
    expect_a("rst2", 2'b00);
    reset_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      edge_once();
      expect_a($sformatf("hold00_%0d", i), 2'b00);
    end

    // one step per edge while enabled
    x1_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge_once();
      expect_a($sformatf("step_%0d", i), seq4[i]);
    end

    // advance to 10 then hold three cycles
    edge_once();
    expect_a("to01", 2'b01);
    edge_once();
    expect_a("to10", 2'b10);
    x1_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_once();
      expect_a($sformatf("hold10_%0d", i), 2'b10);
    end
    check("hold10.dwell_sat", 32'(u_dut.dwell_cnt), 32'd1);
    x1_a = 1'b0;
    edge_once();
    expect_a("resume11", 2'b11);
    check("resume11.dwell", 32'(u_dut.dwell_cnt), 32'd0);

    // reset wins over advance while in 01
    edge_once();
    expect_a("to00b", 2'b00);
    edge_once();
    expect_a("to01b", 2'b01);
    reset_a = 1'b1;
    edge_once();
    expect_a("midrst", 2'b00);
    reset_a = 1'b0;
    edge_once();
    expect_a("post_rst01", 2'b01);
    edge_once();
    expect_a("post_rst10", 2'b10);

    // slow-dwell instance: GREEN_MIN=3, YELLOW_LEN=2
    reset_b = 1'b1;
    edge_once();
    expect_b("slow_rst", 2'b00);
    reset_b = 1'b0;
    x1_b = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      edge_once();
      expect_b($sformatf("slow_%0d", i), slow_pat[i % 10]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
